// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: grant owner encoding, FSM states and
// the default address/data widths used by the surrounding core.
package constants;

  localparam int PC_SIZE     = 32;
  localparam int MEMORY_WORD = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Number of low address bits covered by one cache line of burstLen words
  function automatic int lineLsb(input int burstLen);
    return $clog2(burstLen) + 2;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the I-cache and the
// D-cache. A grant is taken only from IDLE and is held for a whole
// cache-line burst; the RAM address walks the line word by word.
module mem_arbiter
  import constants::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = PC_SIZE,
  parameter int WORD_W    = MEMORY_WORD
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_word,
  output logic              i_word_ready,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_word,
  output logic              d_word_ready,
  output logic              d_done,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output arb_owner_t        owner
);

  localparam int BEAT_W   = $clog2(BURST_LEN);
  localparam int LINE_LSB = lineLsb(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_LSB) - ADDR_W'(1));

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  arb_owner_t        r_lastOwner;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_base;
  logic              r_we;

  logic              w_grantI;
  logic              w_grantD;
  logic              w_lastBeat;
  logic [ADDR_W-1:0] w_beatAddr;

  // On a tie the side that was not served last wins; a lone request always wins
  assign w_grantI   = (r_state == IDLE) && i_req && (!d_req || (r_lastOwner == OWN_D));
  assign w_grantD   = (r_state == IDLE) && d_req && !w_grantI;
  assign w_lastBeat = ram_ready && (r_beat == LAST_BEAT);
  assign w_beatAddr = r_base + ADDR_W'({r_beat, 2'b00});

  // State register
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: arbitrate in IDLE, otherwise stay until the final beat lands
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantI) begin
          w_nextState = SERVE_I;
        end else if (w_grantD) begin
          w_nextState = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (w_lastBeat) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Burst context: line-aligned base, write flag, beat counter, last winner
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_beat      <= '0;
      r_lastOwner <= OWN_D;
      r_base      <= '0;
      r_we        <= 1'b0;
    end else if (w_grantI) begin
      r_base      <= i_addr & LINE_MASK;
      r_we        <= 1'b0;
      r_lastOwner <= OWN_I;
      r_beat      <= '0;
    end else if (w_grantD) begin
      r_base      <= d_addr & LINE_MASK;
      r_we        <= d_we;
      r_lastOwner <= OWN_D;
      r_beat      <= '0;
    end else if ((r_state != IDLE) && ram_ready) begin
      r_beat      <= r_beat + BEAT_W'(1);
    end
  end

  // Outputs are decoded from the state; everything is held at zero while reset is high
  always_comb begin
    owner        = OWN_NONE;
    ram_req      = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    i_word       = '0;
    d_word       = '0;
    i_word_ready = 1'b0;
    i_done       = 1'b0;
    d_word_ready = 1'b0;
    d_done       = 1'b0;
    if (!nrst) begin
      i_word    = ram_rdata;
      d_word    = ram_rdata;
      ram_wdata = d_wdata;
      case (r_state)
        SERVE_I: begin
          owner        = OWN_I;
          ram_req      = 1'b1;
          ram_addr     = w_beatAddr;
          i_word_ready = ram_ready;
          i_done       = w_lastBeat;
        end
        SERVE_D: begin
          owner        = OWN_D;
          ram_req      = 1'b1;
          ram_we       = r_we;
          ram_addr     = w_beatAddr;
          d_word_ready = ram_ready;
          d_done       = w_lastBeat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each scenario pushes the beats it
// expects the RAM port to carry, and a monitor pops and checks a beat every
// time the DUT completes one (ram_req && ram_ready).
module tb_mem_arbiter;
  import constants::*;

  localparam int BURST_LEN = 4;
  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam logic [WORD_W-1:0] RD_KEY = 32'hA5A5_0000;

  typedef struct {
    logic [1:0]        own;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              done;
  } beat_t;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [WORD_W-1:0] i_word;
  logic              i_word_ready;
  logic              i_done;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [WORD_W-1:0] d_wdata = '0;
  logic [WORD_W-1:0] d_word;
  logic              d_word_ready;
  logic              d_done;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_ready = 1'b0;
  arb_owner_t        owner;

  beat_t expQ[$];
  int    vectorCount = 0;
  int    missCount   = 0;
  int    readyMode   = 0;
  bit    sawDone     = 1'b0;

  mem_arbiter #(
    .BURST_LEN(BURST_LEN),
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_word      (i_word),
    .i_word_ready(i_word_ready),
    .i_done      (i_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_word      (d_word),
    .d_word_ready(d_word_ready),
    .d_done      (d_done),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ready   (ram_ready),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  // RAM model: read data is a keyed copy of the address, only while requested
  assign ram_rdata = ram_req ? (ram_addr ^ RD_KEY) : '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushBurst(input logic [1:0] own, input logic we,
                           input logic [ADDR_W-1:0] base, input logic [WORD_W-1:0] wbase,
                           input int beats);
    for (int k = 0; k < beats; k++) begin
      beat_t e;
      e.own   = own;
      e.we    = we;
      e.addr  = base + ADDR_W'(4 * k);
      e.wdata = wbase + WORD_W'(k);
      e.done  = (k == BURST_LEN - 1);
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic dReq);
    @(posedge clk);
    #1;
    i_req = iReq;
    d_req = dReq;
  endtask

  task automatic applyReset(input int cycles);
    nrst  = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    nrst = 1'b0;
  endtask

  // Wait until at most 'target' expected beats remain; optionally drop a
  // request once none of its beats are still outstanding (cache saw done).
  task automatic waitQueue(input int target, input bit dropReqs, input int maxCycles);
    int n = 0;
    forever begin
      bit hasI = 1'b0;
      bit hasD = 1'b0;
      @(negedge clk);
      #1;
      foreach (expQ[j]) begin
        if (expQ[j].own == OWN_I) hasI = 1'b1;
        if (expQ[j].own == OWN_D) hasD = 1'b1;
      end
      if (dropReqs && !hasI) i_req = 1'b0;
      if (dropReqs && !hasD) d_req = 1'b0;
      if (expQ.size() <= target) break;
      n++;
      if (n >= maxCycles) begin
        missCount++;
        $display("[TB] FAIL beat timeout: got %0d beats pending, expected %0d", expQ.size(), target);
        expQ.delete();
        i_req = 1'b0;
        d_req = 1'b0;
        break;
      end
    end
  endtask

  // ram_ready generator: off, every cycle, or every other cycle
  initial begin
    bit toggle = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      toggle = ~toggle;
      case (readyMode)
        1:       ram_ready = 1'b1;
        2:       ram_ready = toggle;
        default: ram_ready = 1'b0;
      endcase
    end
  end

  // Write-back source: present the data of the next expected write beat after each edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0 && expQ[0].we) d_wdata = expQ[0].wdata;
    end
  end

  // Monitor: checks every completed beat against the scoreboard and flags stray strobes
  initial begin
    beat_t e;
    bit    isI;
    forever begin
      @(negedge clk);
      if (sawDone) begin
        sawDone = 1'b0;
        checkOutput("gap ram_req", ram_req, 0);
        checkOutput("gap owner", owner, OWN_NONE);
      end
      if (ram_req && ram_ready) begin
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL unexpected beat: got addr 0x%0h, expected no beat", ram_addr);
        end else begin
          e   = expQ.pop_front();
          isI = (e.own == OWN_I);
          checkOutput("beat owner", owner, e.own);
          checkOutput("ram_addr", ram_addr, e.addr);
          checkOutput("ram_we", ram_we, e.we);
          checkOutput("i_word_ready", i_word_ready, isI);
          checkOutput("d_word_ready", d_word_ready, !isI);
          checkOutput("i_done", i_done, isI && e.done);
          checkOutput("d_done", d_done, !isI && e.done);
          if (e.we) checkOutput("ram_wdata", ram_wdata, e.wdata);
          else if (isI) checkOutput("i_word", i_word, e.addr ^ RD_KEY);
          else checkOutput("d_word", d_word, e.addr ^ RD_KEY);
          if (e.done) sawDone = 1'b1;
        end
      end else if (i_word_ready || d_word_ready || i_done || d_done) begin
        missCount++;
        $display("[TB] FAIL stray strobe: got iwr=%0b dwr=%0b idone=%0b ddone=%0b, expected all 0",
                 i_word_ready, d_word_ready, i_done, d_done);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    // Reset with ram_ready high: outputs must stay quiet
    readyMode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ram_req", ram_req, 0);
    checkOutput("reset owner", owner, OWN_NONE);
    checkOutput("reset i_word_ready", i_word_ready, 0);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset ram_req", ram_req, 0);
    checkOutput("post-reset ram_we", ram_we, 0);
    checkOutput("post-reset ram_addr", ram_addr, 0);
    checkOutput("post-reset owner", owner, OWN_NONE);

    // ram_ready pulsing while idle: nothing moves
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("idle ready ram_req", ram_req, 0);
      checkOutput("idle ready owner", owner, OWN_NONE);
    end

    // I-cache refill alone, one-cycle grant latency, aligned line walk
    pushBurst(OWN_I, 1'b0, 32'h0000_1230, '0, BURST_LEN);
    i_addr = 32'h0000_1234;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("latency pre-grant ram_req", ram_req, 0);
    @(negedge clk);
    checkOutput("latency grant ram_req", ram_req, 1);
    waitQueue(0, 1'b1, 100);

    // Tie right after an I burst: D wins, then I
    pushBurst(OWN_D, 1'b0, 32'h0000_2000, '0, BURST_LEN);
    pushBurst(OWN_I, 1'b0, 32'h0000_3000, '0, BURST_LEN);
    d_addr = 32'h0000_2008;
    i_addr = 32'h0000_3004;
    applyStimulus(1'b1, 1'b1);
    waitQueue(0, 1'b1, 100);

    // Tie after reset: I first, D after the gap; next tie goes to I again
    applyReset(2);
    pushBurst(OWN_I, 1'b0, 32'h0000_1110, '0, BURST_LEN);
    pushBurst(OWN_D, 1'b0, 32'h0000_2200, '0, BURST_LEN);
    i_addr = 32'h0000_111C;
    d_addr = 32'h0000_2204;
    applyStimulus(1'b1, 1'b1);
    waitQueue(0, 1'b1, 100);
    pushBurst(OWN_I, 1'b0, 32'h0000_1400, '0, BURST_LEN);
    pushBurst(OWN_D, 1'b0, 32'h0000_2400, '0, BURST_LEN);
    i_addr = 32'h0000_1408;
    d_addr = 32'h0000_240C;
    applyStimulus(1'b1, 1'b1);
    waitQueue(0, 1'b1, 100);

    // D write-back with ram_ready every other cycle
    readyMode = 2;
    pushBurst(OWN_D, 1'b1, 32'h0000_0080, 32'hC0DE_0000, BURST_LEN);
    d_addr  = 32'h0000_0080;
    d_we    = 1'b1;
    d_wdata = 32'hC0DE_0000;
    applyStimulus(1'b0, 1'b1);
    waitQueue(0, 1'b1, 200);
    d_we      = 1'b0;
    readyMode = 1;

    // I request dropped after beat 1: burst still completes
    pushBurst(OWN_I, 1'b0, 32'h0000_4000, '0, BURST_LEN);
    i_addr = 32'h0000_400C;
    applyStimulus(1'b1, 1'b0);
    waitQueue(2, 1'b0, 100);
    i_req = 1'b0;
    waitQueue(0, 1'b0, 100);

    // Reset during beat 2 of a D refill: burst aborts without done
    pushBurst(OWN_D, 1'b0, 32'h0000_0300, '0, 2);
    d_addr = 32'h0000_030C;
    applyStimulus(1'b0, 1'b1);
    waitQueue(0, 1'b1, 100);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("abort ram_req", ram_req, 0);
    checkOutput("abort d_done", d_done, 0);
    checkOutput("abort owner", owner, OWN_NONE);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    @(negedge clk);
    checkOutput("after abort ram_req", ram_req, 0);
    checkOutput("after abort owner", owner, OWN_NONE);

    // Fresh burst after the abort starts again from beat 0
    pushBurst(OWN_I, 1'b0, 32'h0000_5000, '0, BURST_LEN);
    i_addr = 32'h0000_5000;
    applyStimulus(1'b1, 1'b0);
    waitQueue(0, 1'b1, 100);

    readyMode = 0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, giving memory words per cache-line transfer; legal values are powers of two, 2 to 16.
REQ-002 SHALL have parameter ADDR_W, default `pc_size (32), giving the RAM address width in bits.
REQ-003 SHALL have parameter WORD_W, default `memory_word (32), giving the RAM data width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst, input, 1 bit: synchronous active-high reset (nrst=1 resets).
REQ-006 SHALL have port i_req, input, 1 bit: I-cache refill request, level, held until i_done.
REQ-007 SHALL have port i_addr, input, ADDR_W bits: I-cache miss address.
REQ-008 SHALL have port i_word, output, WORD_W bits: refill data to the I-cache.
REQ-009 SHALL have port i_word_ready, output, 1 bit: one-cycle strobe, i_word valid.
REQ-010 SHALL have port i_done, output, 1 bit: strobe coincident with the final I beat.
REQ-011 SHALL have port d_req, input, 1 bit: D-cache request, level, held until d_done.
REQ-012 SHALL have port d_we, input, 1 bit: 1 = write-back burst, 0 = refill burst.
REQ-013 SHALL have port d_addr, input, ADDR_W bits: D-cache line address.
REQ-014 SHALL have port d_wdata, input, WORD_W bits: write-back data for the current beat.
REQ-015 SHALL have port d_word, output, WORD_W bits: refill data to the D-cache.
REQ-016 SHALL have port d_word_ready, output, 1 bit: per-beat strobe for both read and write; on a write it means "d_wdata accepted, advance".
REQ-017 SHALL have port d_done, output, 1 bit: strobe coincident with the final D beat.
REQ-018 SHALL have port ram_req, output, 1 bit: RAM access request.
REQ-019 SHALL have port ram_we, output, 1 bit: RAM write enable.
REQ-020 SHALL have port ram_addr, output, ADDR_W bits: RAM word address.
REQ-021 SHALL have port ram_wdata, output, WORD_W bits: RAM write data.
REQ-022 SHALL have port ram_rdata, input, WORD_W bits: RAM read data.
REQ-023 SHALL have port ram_ready, input, 1 bit: RAM beat complete, valid only while ram_req=1.
REQ-024 SHALL have port owner, output, arb_owner_t: current grant (OWN_NONE/OWN_I/OWN_D).

Function
REQ-025 FSM SHALL have exactly the states IDLE, SERVE_I and SERVE_D.
REQ-026 Arbitration SHALL occur only in IDLE; a grant is locked until its burst completes.
REQ-027 In IDLE with only one request, that requester SHALL be granted.
REQ-028 In IDLE with both requests, the requester not served last SHALL be granted (round-robin); last_owner resets to OWN_D, so I wins the first tie.
REQ-029 On grant, the granted address SHALL be latched with its low log2(BURST_LEN)+2 bits cleared (line-aligned), and d_we latched.
REQ-030 ram_req SHALL rise the cycle after the grant decision (request seen in IDLE at cycle N -> ram_req=1 at N+1).
REQ-031 ram_addr SHALL equal base + 4*beat; the beat counter runs 0..BURST_LEN-1, increments on ram_ready, and never crosses the line.
REQ-032 ram_we SHALL be 1 only in SERVE_D with latched d_we=1; ram_wdata SHALL be d_wdata driven combinationally.
REQ-033 i_word and d_word SHALL be ram_rdata passed through combinationally.
REQ-034 i_word_ready SHALL equal ram_ready in SERVE_I; d_word_ready SHALL equal ram_ready in SERVE_D; both SHALL be 0 otherwise.
REQ-035 i_done/d_done SHALL assert with ram_ready on beat BURST_LEN-1; the FSM then returns to IDLE, giving a one-cycle gap between bursts.
REQ-036 Deassertion of a request mid-burst SHALL be ignored: the burst completes with no abort.
REQ-037 A request arriving during a final beat SHALL be arbitrated in the following IDLE cycle.
REQ-038 ram_ready while ram_req=0 SHALL be ignored.
REQ-039 owner SHALL be OWN_NONE in IDLE.

Reset
REQ-040 On nrst=1 at a clock edge: state=IDLE, beat=0, last_owner=OWN_D, latched address=0, latched d_we=0.
REQ-041 During and after reset, all outputs SHALL be 0 (owner=OWN_NONE).
REQ-042 A reset mid-burst SHALL abort it: no done strobe, and ram_req=0 from the next cycle.

Structure
REQ-043 arb_owner_t and the FSM state enum SHALL be defined in package constants.
REQ-044 The block SHALL be a single module with no sub-modules.

Verification
REQ-045 The bench SHALL cover: i_req only, i_addr=0x0000_1234, BURST_LEN=4, ram_ready every cycle -> ram_addr 0x1230, 0x1234, 0x1238, 0x123C; i_done on the 4th beat.
REQ-046 The bench SHALL cover: i_req and d_req rising in the same cycle after reset -> I served first, then after the 1-cycle gap D served; next tie -> I.
REQ-047 The bench SHALL cover: d_we=1, d_addr=0x80, ram_ready every other cycle -> ram_we=1 for 4 beats, ram_addr 0x80..0x8C, d_word_ready exactly 4 times, d_done on the last.
REQ-048 The bench SHALL cover: i_req dropped after beat 1 -> beats 2 and 3 still issued, i_done strobes.
REQ-049 The bench SHALL cover: nrst=1 at beat 2 of a D burst -> ram_req=0 next cycle, no d_done, owner=OWN_NONE.
REQ-050 The bench SHALL cover: ram_ready pulsed while IDLE -> no strobes and no state change.
